amm_burst_reader: RTL and testbench
===================================

Name: amm_burst_reader

Overview:
- Avalon-MM read master that fetches a contiguous region of words from memory and presents them as a valid/ready stream, with a per-byte keep mask and a last flag.
- Sits directly upstream of the byte-increment datapath and drives the reader half of the shared Avalon-MM bus (address, read, waitrequest, data, datavalid).
- Bounded outstanding reads plus an internal skid FIFO. Downstream backpressure never drops data and never violates the bus protocol.

Parameters:
- DATA_WIDTH, 64: bus and stream data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10: word address width.
- BYTE_CNT, DATA_WIDTH/8: bytes per word; derived, do not override.
- MAX_OUTSTANDING, 4: FIFO depth and cap on issued-but-unconsumed reads; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- base_addr_i  in  ADDR_WIDTH  first word address; sampled on accept.
- length_i  in  ADDR_WIDTH+$clog2(BYTE_CNT)+1  transfer length in bytes; sampled on accept.
- run_valid_i  in  1  start request.
- busy_o  out  1  high while a transfer is active; run_valid_i is ignored while high.
- amm_address_o  out  ADDR_WIDTH  read word address.
- amm_read_o  out  1  read request.
- amm_waitrequest_i  in  1  slave stall.
- amm_readdata_i  in  DATA_WIDTH  read data.
- amm_readdatavalid_i  in  1  read data valid.
- st_data_o  out  DATA_WIDTH  stream data.
- st_keep_o  out  BYTE_CNT  valid byte mask; bit i covers byte [8i+7:8i].
- st_last_o  out  1  final word of the transfer.
- st_valid_o  out  1  stream valid.
- st_ready_i  in  1  stream ready.

Behaviour:
- Clock and reset: single clock; srst is synchronous and active-high.
- Reset state: busy_o, amm_read_o, st_valid_o and st_last_o are 0; amm_address_o, st_data_o and st_keep_o are 0. FIFO and all counters are cleared; FSM goes to IDLE.
- Word count: words = ceil(length_i / BYTE_CNT).
- Keep mask: all ones on every word except the last. On the last word, the low (length_i mod BYTE_CNT) bits are set, or all bits if the remainder is 0.
- FSM state IDLE: on run_valid_i=1, latch inputs and set busy_o=1 on the next cycle.
  - If length_i=0: go to DONE; no reads and no stream beats are issued.
  - Otherwise: go to READ.
- FSM state READ: amm_read_o=1 while (issued - popped) < MAX_OUTSTANDING.
  - A read is accepted when amm_read_o=1 and amm_waitrequest_i=0. On accept, amm_address_o increments by 1, wrapping modulo 2^ADDR_WIDTH.
  - While amm_waitrequest_i=1, amm_read_o and amm_address_o hold stable.
  - After the last word is accepted: amm_read_o=0 and go to DRAIN.
- FSM state DRAIN: wait until every issued read has returned and the FIFO is empty with its last beat popped, then go to DONE.
- FSM state DONE: busy_o=0 for exactly one cycle, then go to IDLE. This is a single-cycle pulse; a new run is accepted on the cycle after DONE.
- Read latency: first amm_read_o is asserted 1 cycle after accept.
- Response capture: each amm_readdatavalid_i pushes amm_readdata_i into the FIFO in order. The credit rule guarantees the FIFO never overflows.
- FIFO output: show-ahead. st_valid_o = FIFO not empty; a pop happens when st_valid_o & st_ready_i.
  - st_last_o and st_keep_o are computed from the popped-beat index, not the issue index.
- Simultaneous push and pop: both occur in the same cycle; FIFO occupancy is unchanged.
- Stream stability: when st_ready_i=0, st_data_o, st_keep_o and st_last_o stay stable while st_valid_o=1.
- Stray responses: amm_readdatavalid_i with zero reads outstanding (e.g. after a mid-transfer srst) is ignored.
- Reset mid-operation: abandons the transfer immediately; no further reads and no further stream beats.

Optional Feature:
- Macro: AMM_BURST_READER_STATS_EN.
- With the macro defined, two extra outputs are added:
  - stall_cnt_o (32 bits): counts cycles with amm_read_o & amm_waitrequest_i.
  - bp_cnt_o (32 bits): counts cycles with st_valid_o & !st_ready_i.
- Both counters clear on srst and on run accept, and saturate at all-ones.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic run: base=0x010, length=24, no stalls, ready=1 -> reads 0x010..0x012; 3 beats, keep=0xFF on each, last on beat 3; busy_o low 1 cycle after the last pop.
- Partial tail: length=13 -> 2 beats; beat 2 keep=0x1F, last=1.
- Zero length: length=0 -> no amm_read_o, no st_valid_o; busy_o pulses 1 cycle, then the next run is accepted.
- Address wrap with slave stalls: base=0x3FE, length=32, waitrequest high 2 of every 3 cycles -> addresses 0x3FE,0x3FF,0x000,0x001; address and read held stable during every stall.
- Backpressure: length=80, st_ready_i=0 for 20 cycles -> at most 4 reads outstanding; no data loss; beats in order; keep/last correct.
- Mid-transfer reset: srst after 2 accepted reads, then 2 stray datavalid pulses -> no stream output, busy_o=0, FIFO empty; a new run then completes correctly.

Source files
------------

// File: rtl/amm_burst_reader.sv
// amm_burst_reader
//   Avalon-MM read master that fetches a contiguous run of words starting at
//   base_addr_i and covering length_i bytes. Words are returned through a
//   small show-ahead FIFO as a valid/ready stream with a per-byte keep mask
//   and a last flag on the final word.
//
//   Issued-but-unpopped reads are capped at MAX_OUTSTANDING, which is also
//   the FIFO depth. Every response therefore always has a free FIFO slot,
//   and downstream backpressure simply throttles the read issue.
//
//   Optional build macro: AMM_BURST_READER_STATS_EN adds stall_cnt_o and
//   bp_cnt_o. These are saturating 32-bit event counters that clear on srst
//   and on run accept.
module amm_burst_reader #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 10,
    parameter int BYTE_CNT        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 srst,
    input  logic [ADDR_WIDTH-1:0]                base_addr_i,
    input  logic [ADDR_WIDTH+$clog2(BYTE_CNT):0] length_i,
    input  logic                                 run_valid_i,
    output logic                                 busy_o,
`ifdef AMM_BURST_READER_STATS_EN
    output logic [31:0]                          stall_cnt_o,
    output logic [31:0]                          bp_cnt_o,
`endif
    output logic [ADDR_WIDTH-1:0]                amm_address_o,
    output logic                                 amm_read_o,
    input  logic                                 amm_waitrequest_i,
    input  logic [DATA_WIDTH-1:0]                amm_readdata_i,
    input  logic                                 amm_readdatavalid_i,
    output logic [DATA_WIDTH-1:0]                st_data_o,
    output logic [BYTE_CNT-1:0]                  st_keep_o,
    output logic                                 st_last_o,
    output logic                                 st_valid_o,
    input  logic                                 st_ready_i
);

    localparam int BL_W   = $clog2(BYTE_CNT);
    localparam int LEN_W  = ADDR_WIDTH + BL_W + 1;
    localparam int CNT_W  = LEN_W;
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int OCNT_W = PTR_W + 1;
    localparam logic [OCNT_W-1:0] MAX_OUT = OCNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of bus words needed to cover len bytes (ceiling division).
    function automatic logic [CNT_W-1:0] word_count(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(BYTE_CNT - 1);
        return CNT_W'(sum >> BL_W);
    endfunction

    // Keep mask of the final word: low (len mod BYTE_CNT) bytes, or all bytes
    // when the length is an exact multiple of the word size.
    function automatic logic [BYTE_CNT-1:0] tail_keep(input logic [LEN_W-1:0] len);
        logic [BL_W-1:0]     rem;
        logic [BYTE_CNT-1:0] mask;
        rem  = len[BL_W-1:0];
        mask = '0;
        for (int i = 0; i < BYTE_CNT; i++) begin
            if ((rem == BL_W'(0)) || (i < int'(rem))) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_W-1:0]        words_q;
    logic [BYTE_CNT-1:0]     tail_keep_q;
    logic [CNT_W-1:0]        issued_q;
    logic [CNT_W-1:0]        popped_q;
    logic [OCNT_W-1:0]       out_cnt_q;
    logic [OCNT_W-1:0]       inflight_q;
    logic [DATA_WIDTH-1:0]   mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [OCNT_W-1:0]       fifo_cnt_q;

    logic                    run_accept_s;
    logic                    read_s;
    logic                    rd_accept_s;
    logic                    push_s;
    logic                    st_valid_s;
    logic                    pop_s;
    logic                    is_tail_s;

    // A run is only taken from IDLE; DONE and the active states ignore requests.
    assign run_accept_s = (state_q == ST_IDLE) && run_valid_i;
    // Credit gate: never more reads issued than there are FIFO slots to hold them.
    assign read_s       = (state_q == ST_READ) && (out_cnt_q < MAX_OUT);
    assign rd_accept_s  = read_s && !amm_waitrequest_i;
    // Responses with nothing in flight (e.g. left over from before a reset) are dropped.
    assign push_s       = amm_readdatavalid_i && (inflight_q != '0);
    assign st_valid_s   = (fifo_cnt_q != '0);
    assign pop_s        = st_valid_s && st_ready_i;
    assign is_tail_s    = (popped_q == (words_q - CNT_W'(1)));

    assign busy_o        = busy_q;
    assign amm_address_o = addr_q;
    assign amm_read_o    = read_s;
    assign st_valid_o    = st_valid_s;
    assign st_data_o     = st_valid_s ? mem_q[rd_ptr_q] : '0;
    assign st_keep_o     = st_valid_s ? (is_tail_s ? tail_keep_q : {BYTE_CNT{1'b1}}) : '0;
    assign st_last_o     = st_valid_s && is_tail_s;

    // Next-state and busy decode. Busy rises on every accept, so that even a
    // zero-length run shows a one-cycle busy pulse; DONE itself drives busy low.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (run_valid_i) begin
                    busy_d = 1'b1;
                    if (length_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                busy_d = 1'b1;
                if (rd_accept_s && ((issued_q + CNT_W'(1)) == words_q)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pop_s && ((popped_q + CNT_W'(1)) == words_q) && (inflight_q == '0)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and busy registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Latch the transfer description on accept; the address then walks one word per accepted read.
    always_ff @(posedge clk) begin
        if (srst) begin
            addr_q      <= '0;
            words_q     <= '0;
            tail_keep_q <= '0;
        end else if (run_accept_s) begin
            addr_q      <= base_addr_i;
            words_q     <= word_count(length_i);
            tail_keep_q <= tail_keep(length_i);
        end else if (rd_accept_s) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
        end else begin
            addr_q      <= addr_q;
        end
    end

    // Issue and pop indices of the current transfer.
    always_ff @(posedge clk) begin
        if (srst || run_accept_s) begin
            issued_q <= '0;
            popped_q <= '0;
        end else begin
            if (rd_accept_s) begin
                issued_q <= issued_q + CNT_W'(1);
            end else begin
                issued_q <= issued_q;
            end
            if (pop_s) begin
                popped_q <= popped_q + CNT_W'(1);
            end else begin
                popped_q <= popped_q;
            end
        end
    end

    // Credit count: reads issued but whose beat has not yet left the FIFO.
    always_ff @(posedge clk) begin
        if (srst) begin
            out_cnt_q <= '0;
        end else begin
            case ({rd_accept_s, pop_s})
                2'b10:   out_cnt_q <= out_cnt_q + OCNT_W'(1);
                2'b01:   out_cnt_q <= out_cnt_q - OCNT_W'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // In-flight count: reads issued whose response has not yet arrived.
    always_ff @(posedge clk) begin
        if (srst) begin
            inflight_q <= '0;
        end else begin
            case ({rd_accept_s, push_s})
                2'b10:   inflight_q <= inflight_q + OCNT_W'(1);
                2'b01:   inflight_q <= inflight_q - OCNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + OCNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - OCNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the stream data reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= amm_readdata_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

`ifdef AMM_BURST_READER_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bp_cnt_q;

    assign stall_cnt_o = stall_cnt_q;
    assign bp_cnt_o    = bp_cnt_q;

    // Saturating counters for slave stall cycles and downstream backpressure cycles.
    always_ff @(posedge clk) begin
        if (srst || run_accept_s) begin
            stall_cnt_q <= '0;
            bp_cnt_q    <= '0;
        end else begin
            if (read_s && amm_waitrequest_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (st_valid_s && !st_ready_i && (bp_cnt_q != 32'hFFFF_FFFF)) begin
                bp_cnt_q <= bp_cnt_q + 32'd1;
            end else begin
                bp_cnt_q <= bp_cnt_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_amm_burst_reader.sv
// Self-checking bench for amm_burst_reader: table-driven directed runs,
// hand-written reset/zero-length sequences and randomized runs against a
// transaction-level model (expected beat list + expected address stream).
module tb_amm_burst_reader;
    localparam int DW   = 64;
    localparam int AW   = 10;
    localparam int BC   = 8;
    localparam int LW   = AW + 3 + 1;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          srst;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] length_i;
    logic          run_valid_i;
    logic          busy_o;
    logic [AW-1:0] amm_address_o;
    logic          amm_read_o;
    logic          amm_waitrequest_i;
    logic [DW-1:0] amm_readdata_i;
    logic          amm_readdatavalid_i;
    logic [DW-1:0] st_data_o;
    logic [BC-1:0] st_keep_o;
    logic          st_last_o;
    logic          st_valid_o;
    logic          st_ready_i;

    amm_burst_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .srst(srst),
        .base_addr_i(base_addr_i), .length_i(length_i), .run_valid_i(run_valid_i),
        .busy_o(busy_o),
        .amm_address_o(amm_address_o), .amm_read_o(amm_read_o),
        .amm_waitrequest_i(amm_waitrequest_i), .amm_readdata_i(amm_readdata_i),
        .amm_readdatavalid_i(amm_readdatavalid_i),
        .st_data_o(st_data_o), .st_keep_o(st_keep_o), .st_last_o(st_last_o),
        .st_valid_o(st_valid_o), .st_ready_i(st_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [BC-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            wmode;
        int            rmode;
        int            exp_beats;
        logic [BC-1:0] exp_tail_keep;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    longint        cyc = 0;

    // Slave model state: accepted addresses awaiting response, with due cycles.
    logic [AW-1:0] sl_addr_q[$];
    longint        sl_due_q[$];
    longint        sl_last_due = 0;
    int            stray_n = 0;

    // Reference model state for the current transfer.
    beat_t         exp_q[$];
    logic [AW-1:0] exp_addr;
    int            reads_left = 0;
    int            outstanding = 0;
    longint        last_pop_cyc = -1;
    int            beats_seen = 0;
    logic [BC-1:0] tail_keep_seen = '0;
    int            wmode_g = 0;
    int            rmode_g = 0;
    longint        start_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents as seen by the slave: address-tagged so misordering is visible.
    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {16'hC0DE, 6'd0, a, 22'd0, a};
    endfunction

    // Build the expected beat list straight from length/base arithmetic.
    task automatic model_start(input logic [AW-1:0] base, input logic [LW-1:0] len);
        int    words;
        int    rem;
        beat_t b;
        exp_q.delete();
        words = (int'(len) + BC - 1) / BC;
        rem   = int'(len) % BC;
        for (int k = 0; k < words; k++) begin
            b.data = word_of(AW'(int'(base) + k));
            b.last = (k == words - 1);
            if (b.last && rem != 0) b.keep = 8'((1 << rem) - 1);
            else                    b.keep = 8'hFF;
            exp_q.push_back(b);
        end
        exp_addr       = base;
        reads_left     = words;
        outstanding    = 0;
        last_pop_cyc   = -1;
        beats_seen     = 0;
        tail_keep_seen = '0;
    endtask

    // One clock cycle: drive slave response, observe handshakes, advance, check.
    task automatic step();
        logic          rst_now, rd_fire, stall_now, pop_now, hold_now, rsp_fire;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] pdata;
        logic [BC-1:0] pkeep;
        logic          plast;
        longint        due;
        rsp_fire = 1'b0;
        if (stray_n > 0) begin
            amm_readdatavalid_i = 1'b1;
            amm_readdata_i      = 64'hBAD0_BAD0_BAD0_BAD0;
            stray_n--;
        end else if (sl_addr_q.size() > 0 && sl_due_q[0] <= cyc) begin
            amm_readdatavalid_i = 1'b1;
            amm_readdata_i      = word_of(sl_addr_q[0]);
            rsp_fire            = 1'b1;
        end else begin
            amm_readdatavalid_i = 1'b0;
            amm_readdata_i      = {$urandom, $urandom};
        end
        rst_now   = srst;
        rd_fire   = amm_read_o && !amm_waitrequest_i;
        stall_now = amm_read_o && amm_waitrequest_i;
        rd_addr   = amm_address_o;
        pop_now   = st_valid_o && st_ready_i;
        hold_now  = st_valid_o && !st_ready_i;
        pdata     = st_data_o;
        pkeep     = st_keep_o;
        plast     = st_last_o;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_fire) begin
            void'(sl_addr_q.pop_front());
            void'(sl_due_q.pop_front());
        end
        if (!rst_now) begin
            if (rd_fire) begin
                chk("read_expected", 64'(reads_left > 0), 64'd1);
                if (reads_left > 0) begin
                    chk("read_addr", 64'(rd_addr), 64'(exp_addr));
                    exp_addr++;
                    reads_left--;
                    outstanding++;
                    chk("outstanding_cap", 64'(outstanding <= MAXO), 64'd1);
                    due = cyc + longint'($urandom_range(1, 3));
                    if (due <= sl_last_due) due = sl_last_due + 1;
                    sl_last_due = due;
                    sl_addr_q.push_back(rd_addr);
                    sl_due_q.push_back(due);
                end
            end
            if (pop_now) begin
                chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    chk("beat_data", pdata, exp_q[0].data);
                    chk("beat_keep", 64'(pkeep), 64'(exp_q[0].keep));
                    chk("beat_last", 64'(plast), 64'(exp_q[0].last));
                    outstanding--;
                    beats_seen++;
                    if (plast) tail_keep_seen = pkeep;
                    if (exp_q[0].last) last_pop_cyc = cyc;
                    void'(exp_q.pop_front());
                end
            end
            if (stall_now) begin
                chk("stall_read_held", 64'(amm_read_o), 64'd1);
                chk("stall_addr_held", 64'(amm_address_o), 64'(rd_addr));
            end
            if (hold_now) begin
                chk("hold_valid", 64'(st_valid_o), 64'd1);
                chk("hold_data", st_data_o, pdata);
                chk("hold_keep", 64'(st_keep_o), 64'(pkeep));
                chk("hold_last", 64'(st_last_o), 64'(plast));
            end
        end
        case (wmode_g)
            0:       amm_waitrequest_i = 1'b0;
            1:       amm_waitrequest_i = ((cyc % 3) != 0);
            default: amm_waitrequest_i = 1'($urandom_range(0, 1));
        endcase
        case (rmode_g)
            0:       st_ready_i = 1'b1;
            1:       st_ready_i = ($urandom_range(0, 3) != 0);
            default: st_ready_i = ((cyc - start_cyc) >= 20);
        endcase
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},  64'(busy_o), 64'd0);
        chk({tag, "_read"},  64'(amm_read_o), 64'd0);
        chk({tag, "_valid"}, 64'(st_valid_o), 64'd0);
        chk({tag, "_last"},  64'(st_last_o), 64'd0);
        chk({tag, "_addr"},  64'(amm_address_o), 64'd0);
        chk({tag, "_data"},  st_data_o, 64'd0);
        chk({tag, "_keep"},  64'(st_keep_o), 64'd0);
    endtask

    // Launch one run from IDLE and follow it until busy drops.
    task automatic run_xfer(input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input int wm, input int rm, input int settle,
                            output int nbeats, output logic [BC-1:0] tkeep);
        int n;
        model_start(base, len);
        wmode_g     = wm;
        rmode_g     = rm;
        start_cyc   = cyc;
        base_addr_i = base;
        length_i    = len;
        run_valid_i = 1'b1;
        step();
        run_valid_i = 1'b0;
        base_addr_i = AW'($urandom);
        length_i    = LW'($urandom);
        chk("busy_after_accept", 64'(busy_o), 64'd1);
        chk("first_read_latency", 64'(amm_read_o), 64'(len != '0));
        n = 0;
        while (busy_o && n < 3000) begin
            step();
            n++;
        end
        chk("finish_in_budget", 64'(n < 3000), 64'd1);
        chk("beats_remaining", 64'(exp_q.size()), 64'd0);
        chk("reads_remaining", 64'(reads_left), 64'd0);
        if (len != '0) chk("busy_low_after_last_pop", 64'(cyc), 64'(last_pop_cyc));
        else           chk("zero_len_busy_cycles", 64'(n), 64'd1);
        nbeats = beats_seen;
        tkeep  = tail_keep_seen;
        for (int s = 0; s < settle; s++) step();
    endtask

    initial begin
        vec_t          vecs[6];
        int            nb;
        logic [BC-1:0] tk;
        int            n;
        int            rlen;

        vecs[0] = '{10'h010, 14'd24, 0, 0, 3,  8'hFF};
        vecs[1] = '{10'h020, 14'd13, 0, 0, 2,  8'h1F};
        vecs[2] = '{10'h3FE, 14'd32, 1, 0, 4,  8'hFF};
        vecs[3] = '{10'h100, 14'd80, 0, 2, 10, 8'hFF};
        vecs[4] = '{10'h055, 14'd1,  2, 1, 1,  8'h01};
        vecs[5] = '{10'h3FF, 14'd63, 2, 1, 8,  8'h7F};

        srst                = 1'b1;
        base_addr_i         = '0;
        length_i            = '0;
        run_valid_i         = 1'b0;
        amm_waitrequest_i   = 1'b0;
        amm_readdata_i      = '0;
        amm_readdatavalid_i = 1'b0;
        st_ready_i          = 1'b1;
        repeat (3) step();
        check_reset_state("reset");
        srst = 1'b0;
        step();

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].base, vecs[i].len, vecs[i].wmode, vecs[i].rmode, 1, nb, tk);
            chk("vec_beats", 64'(nb), 64'(vecs[i].exp_beats));
            chk("vec_tail_keep", 64'(tk), 64'(vecs[i].exp_tail_keep));
        end

        // Zero length, then a new run in the very next cycle after the busy pulse.
        run_xfer(10'h200, 14'd0, 0, 0, 0, nb, tk);
        chk("zero_len_beats", 64'(nb), 64'd0);
        run_xfer(10'h030, 14'd16, 0, 0, 1, nb, tk);
        chk("after_zero_beats", 64'(nb), 64'd2);

        // Mid-transfer reset after two accepted reads, then stray responses.
        model_start(10'h080, 14'd80);
        wmode_g     = 0;
        rmode_g     = 0;
        base_addr_i = 10'h080;
        length_i    = 14'd80;
        run_valid_i = 1'b1;
        step();
        run_valid_i = 1'b0;
        n = 0;
        while ((10 - reads_left) < 2 && n < 50) begin
            step();
            n++;
        end
        chk("two_reads_seen", 64'(10 - reads_left), 64'd2);
        srst = 1'b1;
        step();
        srst = 1'b0;
        exp_q.delete();
        sl_addr_q.delete();
        sl_due_q.delete();
        reads_left  = 0;
        outstanding = 0;
        check_reset_state("midrst");
        stray_n = 2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_valid", 64'(st_valid_o), 64'd0);
            chk("post_rst_read", 64'(amm_read_o), 64'd0);
            chk("post_rst_busy", 64'(busy_o), 64'd0);
        end
        run_xfer(10'h3F0, 14'd40, 2, 1, 1, nb, tk);
        chk("post_rst_run_beats", 64'(nb), 64'd5);
        chk("post_rst_run_keep", 64'(tk), 64'hFF);

        // Randomized runs against the model.
        for (int i = 0; i < 12; i++) begin
            rlen = int'($urandom_range(0, 120));
            run_xfer(AW'($urandom), LW'(rlen), 2, 1, 1, nb, tk);
            chk("rand_beats", 64'(nb), 64'((rlen + BC - 1) / BC));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
